// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader packing a byte stream into 32-bit Imem words
// Optional checksum byte after the image: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int ADDR_W    = 32,
    parameter int LEN_W     = 8,
    parameter int MAX_WORDS = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WR, S_CHK, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WR, S_DONE} state_t;
`endif

    localparam logic [LEN_W:0] MAX_L = (LEN_W+1)'(MAX_WORDS);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         idx_q, idx_d;
    logic [31:0]        asm_q, asm_d;
    logic               err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]         ck_q, ck_d;
`endif

    logic start_ok;
    logic accept;

    assign start_ok = start && (len != '0) && ({1'b0, len} <= MAX_L);
    assign accept   = byte_valid && byte_ready;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        asm_d   = asm_q;
        err_d   = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        ck_d    = ck_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_ok) begin
                    state_d = S_LOAD;
                    addr_d  = '0;
                    len_d   = len;
                    cnt_d   = '0;
                    idx_d   = '0;
                    asm_d   = '0;
                    err_d   = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    ck_d    = '0;
`endif
                end else if (start) begin
                    err_d = 1'b1;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    asm_d[8*idx_q +: 8] = byte_data;
                    idx_d = idx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    ck_d  = ck_q ^ byte_data;
`endif
                    if (idx_q == 2'd3) begin
                        state_d = S_WR;
                    end
                end
            end
            S_WR: begin
                // Address and count advance only once the write strobe has been seen.
                addr_d = addr_q + ADDR_W'(4);
                cnt_d  = cnt_q + LEN_W'(1);
                if (cnt_d == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = S_CHK;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_LOAD;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (accept) begin
                    if (byte_data == ck_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            asm_q   <= '0;
            err_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            ck_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            err_q   <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            ck_q    <= ck_d;
`endif
        end
    end

    // Byte intake pauses during the write cycle so a new word never overwrites wdata.
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign byte_ready = (state_q == S_LOAD) || (state_q == S_CHK);
    assign busy       = (state_q == S_LOAD) || (state_q == S_WR) || (state_q == S_CHK);
`else
    assign byte_ready = (state_q == S_LOAD);
    assign busy       = (state_q == S_LOAD) || (state_q == S_WR);
`endif
    assign imem_we    = (state_q == S_WR);
    assign imem_addr  = addr_q;
    assign imem_wdata = asm_q;
    assign done       = (state_q == S_DONE);
    assign core_rst   = (state_q != S_DONE);
    assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  len = 8'd0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'd0;
    logic        byte_ready, imem_we, core_rst, busy, done, err;
    logic [31:0] imem_addr, imem_wdata;

    int tests = 0;
    int fails = 0;
    logic [63:0] wq[$];
    logic [31:0] img[$];

    imem_loader #(.ADDR_W(32), .LEN_W(8), .MAX_WORDS(64)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_rst(core_rst), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we === 1'b1) wq.push_back({imem_addr, imem_wdata});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_core_rst"}, core_rst, 1);
        chk({tag, "_imem_we"}, imem_we, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_byte_ready"}, byte_ready, 0);
        chk({tag, "_addr"}, imem_addr, 0);
        chk({tag, "_wdata"}, imem_wdata, 0);
    endtask

    task automatic bad_start(input logic [7:0] l);
        wq.delete();
        @(negedge clk); start = 1'b1; len = l;
        @(negedge clk); start = 1'b0;
        #1;
        chk("bad_start_err", err, 1);
        chk("bad_start_busy", busy, 0);
        chk("bad_start_core_rst", core_rst, 1);
        repeat (3) @(negedge clk);
        #1 chk("bad_start_no_write", wq.size(), 0);
    endtask

    // mode 0: back-to-back, 1: random bubbles, 2: fixed 3-cycle gap
    task automatic load(input int mode, input bit inject, input bit corrupt);
        logic [7:0] bytes[$];
        logic [7:0] ck = 8'd0;
        int i = 0;
        int cyc = 0;
        bit acc;
        foreach (img[w]) begin
            for (int k = 0; k < 4; k++) begin
                bytes.push_back(img[w][8*k +: 8]);
                ck ^= img[w][8*k +: 8];
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        bytes.push_back(ck ^ {7'd0, corrupt});
`endif
        wq.delete();
        @(negedge clk); start = 1'b1; len = 8'(img.size());
        @(negedge clk); start = 1'b0;
        #1;
        chk("start_busy", busy, 1);
        chk("start_err_clear", err, 0);
        chk("start_core_rst", core_rst, 1);
        chk("start_done_clear", done, 0);
        while (i < bytes.size() && cyc < 4000) begin
            @(negedge clk);
            case (mode)
                0: byte_valid = 1'b1;
                1: byte_valid = ($urandom_range(0, 2) != 0);
                default: byte_valid = !(cyc >= 3 && cyc <= 5);
            endcase
            byte_data = bytes[i];
            start = inject && (i == 2);
            if (inject && i == 2) len = 8'd1;
            #1 acc = byte_valid && byte_ready;
            @(posedge clk);
            if (acc) i++;
            cyc++;
        end
        chk("all_bytes_accepted", i, bytes.size());
        @(negedge clk); byte_valid = 1'b0; start = 1'b0;
`ifndef IMEM_LOADER_CHECKSUM_EN
        #1 chk("last_write_strobe", imem_we, 1);
        @(negedge clk);
`endif
        #1;
        if (corrupt) begin
            chk("cks_bad_err", err, 1);
            chk("cks_bad_done", done, 0);
            chk("cks_bad_core_rst", core_rst, 1);
            chk("cks_bad_busy", busy, 0);
        end else begin
            chk("end_done", done, 1);
            chk("end_core_rst", core_rst, 0);
            chk("end_busy", busy, 0);
            chk("end_err", err, 0);
        end
        byte_valid = 1'b1; byte_data = 8'hAA;
        #1 chk("idle_byte_ready", byte_ready, 0);
        repeat (2) @(negedge clk);
        byte_valid = 1'b0;
        #1;
        chk("write_count", wq.size(), img.size());
        for (int w = 0; w < img.size() && w < wq.size(); w++)
            chk($sformatf("write_%0d", w), wq[w], {32'(4 * w), img[w]});
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk); rst = 1'b1;

        bad_start(8'd0);
        bad_start(8'd65);
        bad_start(8'($urandom_range(66, 255)));

        img = '{32'h00500113, 32'h00C00193};
        load(0, 1'b0, 1'b0);
        load(2, 1'b0, 1'b0);
        load(1, 1'b1, 1'b0);

        repeat (6) begin
            img.delete();
            repeat ($urandom_range(1, 8)) img.push_back($urandom);
            load($urandom_range(0, 2), bit'($urandom_range(0, 1)), 1'b0);
        end
        img.delete();
        repeat (64) img.push_back($urandom);
        load(0, 1'b0, 1'b0);

        begin
            int got = 0;
            int cyc = 0;
            @(negedge clk); start = 1'b1; len = 8'd2;
            @(negedge clk); start = 1'b0;
            while (got < 5 && cyc < 100) begin
                @(negedge clk); byte_valid = 1'b1; byte_data = 8'(got + 1);
                #1 if (byte_ready) got++;
                @(posedge clk);
                cyc++;
            end
            @(negedge clk); byte_valid = 1'b0; rst = 1'b0;
            #1 check_reset_outputs("mid_load_reset");
            @(negedge clk); rst = 1'b1;
        end
        img = '{32'h00500113};
        load(0, 1'b0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        img = '{32'h00500113, 32'h00C00193};
        load(0, 1'b0, 1'b1);
        load(1, 1'b0, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
